pin_chain_tester: RTL and testbench
===================================

# pin_chain_tester

Parametrised pin-chain continuity tester for the pico-ice test jig. It drives a sequence of patterns onto `N_CH` FPGA output pins, which the jig wiring loops back to `N_CH` input pins. It samples the looped-back values and accumulates a per-channel fail mask, catching opens, stuck-at faults and pin-to-pin shorts. It replaces the fixed 17-wire combinational forwarding chain, and is started and forced high-Z by RP2040 GPIOs.

## Interface
Parameters:
- `N_CH`, 17: number of driven/checked channel pairs (2..32)
- `SETTLE_CYCLES`, 4: cycles the pattern is held before the synchronised inputs are sampled (≥1)
- `SYNC_STAGES`, 2: flop stages on every asynchronous input (≥2)
- `LED_DIV`, 22: blink counter width; while busy, `led_g` toggles every 2^(LED_DIV-1) cycles

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  async, from RP2040; a rising edge starts a run
- `high_z_req`  in  1  async, from RP2040; 1 = release all chain pins
- `chain_in`  in  N_CH  async looped-back pins; bit i pairs with `chain_out[i]`
- `chain_out`  out  N_CH  pattern driven to `SB_IO` `D_OUT_0`
- `chain_oe`  out  1  common `OUTPUT_ENABLE` for all chain `SB_IO`s
- `busy`  out  1  run in progress
- `done`  out  1  last run completed (sticky until next run or reset)
- `pass`  out  1  valid when `done`; 1 = `fail_mask` is zero
- `fail_mask`  out  N_CH  bit i = channel i mismatched in ≥1 pattern
- `led_g`  out  1  to `SB_RGBA_DRV` RGB0PWM

## Operation
- `start`, `high_z_req` and `chain_in` each pass through `SYNC_STAGES` flops. `start` is then edge-detected (rise = `s_start & ~s_start_d`).
- Pattern set: `N_PAT = 2*N_CH+2`, indexed by k:
  - k=0: all zeros
  - k=1: all ones
  - k=2..N_CH+1: walking one, bit k-2
  - k=N_CH+2..2N_CH+1: walking zero, bit k-N_CH-2
- FSM states: IDLE, DRIVE, CHECK, DONE.
  - IDLE/DONE: `chain_out`=0. A start rise loads k=0, clears `fail_mask`, `done` and `pass`, then goes to DRIVE.
  - DRIVE: `chain_out`=pattern(k). A wait counter loaded with `SETTLE_CYCLES+SYNC_STAGES-1` decrements; at 0 the FSM goes to CHECK.
  - CHECK (1 cycle): `fail_mask |= sync_in ^ pattern(k)`. If k=N_PAT-1, go to DONE; else k++ and go to DRIVE.
  - DONE: `done`=1; `pass` = (`fail_mask`==0) using the mask value after the final CHECK.
- `chain_oe` = `~s_high_z`, except 0 during reset.
- A `s_high_z` rise while busy aborts the run: FSM goes to IDLE, `busy`=0, `done`=0, `pass`=0, `fail_mask` holds its partial value.
- A start rise while busy is ignored. A start rise while `s_high_z`=1 is ignored.
- `led_g` drive:
  - IDLE: 0
  - busy: bit LED_DIV-1 of a free-running counter, cleared at run start
  - DONE: `pass`

## Timing
- Reset values: `chain_out`=0, `chain_oe`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `led_g`=0, FSM=IDLE, k=0. Reset mid-run returns everything to these values on the next edge.
- Start latency: `busy` rises SYNC_STAGES+1 cycles after `start` rises at the pin.
- Per-pattern cost: W = SETTLE_CYCLES+SYNC_STAGES+1 cycles.
- `done` rises exactly N_PAT·W cycles after `busy` rises; `busy` falls on the same edge.
- `chain_oe` follows `high_z_req` with SYNC_STAGES+1 cycles latency in both directions.
- Counter widths:
  - k: `$clog2(N_PAT)`
  - wait counter: `$clog2(SETTLE_CYCLES+SYNC_STAGES)`, minimum 1
  - no wrap: k never exceeds N_PAT-1
- All outputs are registered.

## Structure
- Package `pin_chain_pkg`: state enum `pc_state_e` (IDLE, DRIVE, CHECK, DONE), function `pattern(k, N_CH)`, and localparam helper for N_PAT.
- Sub-module `sync_bank #(WIDTH, STAGES)`: a vector multi-flop synchroniser. It is instantiated once for {`start`, `high_z_req`} and once for `chain_in`.
- The top-level jig wrapper instantiates the `SB_IO` array and `SB_RGBA_DRV`. This block stays technology-independent.

## Test plan
Use N_CH=4, SETTLE_CYCLES=2, SYNC_STAGES=2, LED_DIV=3, so W=5 and N_PAT=10.
- Ideal loopback (`chain_in`=`chain_out`), start pulse → `busy` for 50 cycles, then `done`=1, `pass`=1, `fail_mask`=4'b0000, `led_g`=1.
- `chain_in[2]` stuck at 0 → `fail_mask`=4'b0100, `pass`=0, `led_g`=0.
- Short ch1/ch2 (`chain_in[1]`=`chain_in[2]`=`out[1]|out[2]`) → `fail_mask`=4'b0110.
- `high_z_req` raised at cycle 20 of a run → `chain_oe`=0 three cycles later, `busy`=0, `done`=0; a new start while `high_z_req`=1 is ignored.
- Second start pulse at cycle 10 of a run is ignored → `done` still at cycle 50; `rst` at cycle 30 of a run → all outputs 0 next cycle.
- Back-to-back runs: first with the stuck fault, second ideal → the second run clears `fail_mask` and reports `pass`=1.

Source files
------------

// File: rtl/pin_chain_tester_pkg.sv
// Shared types and helpers for the pico-ice pin-chain continuity tester.
package pin_chain_pkg;

  // Widest chain the pattern helper can describe.
  localparam int MAX_CH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } pc_state_e;

  // Number of patterns in one run: zeros, ones, walking one, walking zero.
  function automatic int nPat(input int nCh);
    return 2 * nCh + 2;
  endfunction

  // Pattern k for an nCh-wide chain, right-aligned in a MAX_CH vector.
  function automatic logic [MAX_CH-1:0] pattern(input int k, input int nCh);
    logic [MAX_CH-1:0] allOnes;
    allOnes = {MAX_CH{1'b1}} >> (MAX_CH - nCh);
    if (k == 0) begin
      return '0;
    end else if (k == 1) begin
      return allOnes;
    end else if (k <= nCh + 1) begin
      return MAX_CH'(1) << (k - 2);
    end else begin
      return allOnes & ~(MAX_CH'(1) << (k - nCh - 2));
    end
  endfunction

endpackage

// File: rtl/pin_chain_tester_if.sv
// Pin-level bundle between the jig wrapper (RP2040 GPIOs, SB_IO pins) and the tester.
interface pin_chain_tester_if #(
  parameter int N_CH = 17
);
  logic            start;
  logic            high_z_req;
  logic [N_CH-1:0] chain_in;
  logic [N_CH-1:0] chain_out;
  logic            chain_oe;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_CH-1:0] fail_mask;
  logic            led_g;

  // Jig / RP2040 side: drives control and looped-back pins, observes results.
  modport master (
    output start, high_z_req, chain_in,
    input  chain_out, chain_oe, busy, done, pass, fail_mask, led_g
  );

  // Tester side.
  modport slave (
    input  start, high_z_req, chain_in,
    output chain_out, chain_oe, busy, done, pass, fail_mask, led_g
  );
endinterface

// File: rtl/pin_chain_tester_sync_bank.sv
// Vector multi-flop synchroniser for asynchronous jig inputs.
module sync_bank #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the raw input through STAGES flops; the last stage is safe to use.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/pin_chain_tester.sv
// Pin-chain continuity tester: drives zeros, ones, walking-one and walking-zero
// patterns onto the chain, compares the looped-back pins and accumulates a
// per-channel fail mask. Technology independent; SB_IO/SB_RGBA_DRV live in the
// jig wrapper.
module pin_chain_tester
  import pin_chain_pkg::*;
#(
  parameter int N_CH          = 17,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int LED_DIV       = 22
) (
  input logic              clk,
  input logic              rst,
  pin_chain_tester_if.slave jig
);

  localparam int NPAT  = nPat(N_CH);
  localparam int KW    = $clog2(NPAT);
  localparam int WRAW  = $clog2(SETTLE_CYCLES + SYNC_STAGES);
  localparam int WW    = (WRAW < 1) ? 1 : WRAW;
  localparam logic [KW-1:0] K_LAST    = KW'(NPAT - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(SETTLE_CYCLES + SYNC_STAGES - 1);

  logic [1:0]      ctrlSync;
  logic            sStart;
  logic            sHighZ;
  logic [N_CH-1:0] sIn;
  logic            startRise;

  pc_state_e       state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [WW-1:0]   waitCnt_q, waitCnt_d;
  logic [N_CH-1:0] failMask_q, failMask_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic [N_CH-1:0] chainOut_q, chainOut_d;
  logic            chainOe_q, chainOe_d;
  logic            ledG_q, ledG_d;
  logic [LED_DIV-1:0] blinkCnt_q, blinkCnt_d;
  logic            startDly_q;

  sync_bank #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_syncCtrl (
    .clk (clk),
    .rst (rst),
    .d_i ({jig.start, jig.high_z_req}),
    .q_o (ctrlSync)
  );

  sync_bank #(.WIDTH(N_CH), .STAGES(SYNC_STAGES)) u_syncChain (
    .clk (clk),
    .rst (rst),
    .d_i (jig.chain_in),
    .q_o (sIn)
  );

  assign sStart    = ctrlSync[1];
  assign sHighZ    = ctrlSync[0];
  assign startRise = sStart & ~startDly_q;
  assign chainOe_d = ~sHighZ;

  // Register FSM state, counters and every output so the pins see clean flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      waitCnt_q  <= '0;
      failMask_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      chainOut_q <= '0;
      chainOe_q  <= 1'b0;
      ledG_q     <= 1'b0;
      blinkCnt_q <= '0;
      startDly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      waitCnt_q  <= waitCnt_d;
      failMask_q <= failMask_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      chainOut_q <= chainOut_d;
      chainOe_q  <= chainOe_d;
      ledG_q     <= ledG_d;
      blinkCnt_q <= blinkCnt_d;
      startDly_q <= sStart;
    end
  end

  // Next-state logic: start/abort handling, settle wait, per-pattern compare,
  // and the registered-output values derived from the next state.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    waitCnt_d  = waitCnt_q;
    failMask_d = failMask_q;
    done_d     = done_q;
    pass_d     = pass_q;
    blinkCnt_d = blinkCnt_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (startRise && !sHighZ) begin
          state_d    = DRIVE;
          k_d        = '0;
          waitCnt_d  = WAIT_LOAD;
          failMask_d = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          blinkCnt_d = '0;
        end
      end
      DRIVE: begin
        if (sHighZ) begin
          state_d = IDLE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (waitCnt_q == '0) begin
          state_d = CHECK;
        end else begin
          waitCnt_d = waitCnt_q - 1'b1;
        end
      end
      CHECK: begin
        if (sHighZ) begin
          state_d = IDLE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          failMask_d = failMask_q | (sIn ^ N_CH'(pattern(int'(k_q), N_CH)));
          if (k_q == K_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (failMask_d == '0);
          end else begin
            k_d       = k_q + 1'b1;
            waitCnt_d = WAIT_LOAD;
            state_d   = DRIVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d == DRIVE) || (state_d == CHECK);
    chainOut_d = busy_d ? N_CH'(pattern(int'(k_d), N_CH)) : '0;
    ledG_d     = 1'b0;
    if (state_d == DONE) begin
      ledG_d = pass_d;
    end else if (busy_d) begin
      ledG_d = blinkCnt_d[LED_DIV-1];
    end
  end

  assign jig.chain_out = chainOut_q;
  assign jig.chain_oe  = chainOe_q;
  assign jig.busy      = busy_q;
  assign jig.done      = done_q;
  assign jig.pass      = pass_q;
  assign jig.fail_mask = failMask_q;
  assign jig.led_g     = ledG_q;

endmodule

// File: tb/tb_pin_chain_tester.sv
// Scoreboard bench for pin_chain_tester with N_CH=4, SETTLE=2, SYNC=2, LED_DIV=3
// (W=5, N_PAT=10, so a full run is 50 cycles).
module tb_pin_chain_tester;

  localparam int N_CH    = 4;
  localparam int RUN_LEN = 50;

  typedef struct {
    logic [3:0] mask;
    logic       pass;
  } expEntry_t;

  logic clk;
  logic rst;
  int   faultMode;
  int   testsRun;
  int   testsFailed;
  expEntry_t expQ[$];

  int   monCyc;
  int   monBusyStart;
  logic monBusyPrev;
  logic monDonePrev;

  pin_chain_tester_if #(.N_CH(N_CH)) jig ();

  pin_chain_tester #(
    .N_CH          (N_CH),
    .SETTLE_CYCLES (2),
    .SYNC_STAGES   (2),
    .LED_DIV       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .jig (jig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Jig wiring model: ideal loopback, channel 2 stuck at 0, or ch1/ch2 shorted (wired-OR).
  always_comb begin
    jig.chain_in = jig.chain_out;
    if (faultMode == 1) begin
      jig.chain_in[2] = 1'b0;
    end else if (faultMode == 2) begin
      jig.chain_in[1] = jig.chain_out[1] | jig.chain_out[2];
      jig.chain_in[2] = jig.chain_out[1] | jig.chain_out[2];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    jig.start = 1'b1;
    @(negedge clk);
    jig.start = 1'b0;
  endtask

  // Select the loopback fault, queue the result the run must report, and start it.
  task automatic applyStimulus(input int fault, input bit expectDone, input logic [3:0] expMask, input logic expPass);
    expEntry_t e;
    faultMode = fault;
    if (expectDone) begin
      e.mask = expMask;
      e.pass = expPass;
      expQ.push_back(e);
    end
    pulseStart();
  endtask

  // Bounded wait for busy to reach a level; an expired bound is a failed comparison.
  task automatic waitBusy(input string name, input logic level, input int limit);
    for (int i = 0; i < limit && jig.busy !== level; i++) @(negedge clk);
    checkOutput(name, 32'(jig.busy), 32'(level));
  endtask

  // Monitor: on each done rise, pop the expected result and check mask, pass, led, run length.
  initial begin
    expEntry_t e;
    monCyc = 0;
    monBusyStart = 0;
    monBusyPrev = 1'b0;
    monDonePrev = 1'b0;
    forever begin
      @(negedge clk);
      monCyc++;
      if (jig.busy === 1'b1 && !monBusyPrev) monBusyStart = monCyc;
      if (jig.done === 1'b1 && !monDonePrev) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpectedDone: got done with mask %0h, expected no run", jig.fail_mask);
        end else begin
          e = expQ.pop_front();
          checkOutput("sbFailMask", 32'(jig.fail_mask), 32'(e.mask));
          checkOutput("sbPass", 32'(jig.pass), 32'(e.pass));
          checkOutput("sbLedDone", 32'(jig.led_g), 32'(e.pass));
          checkOutput("sbRunLength", monCyc - monBusyStart, RUN_LEN);
        end
      end
      monBusyPrev = (jig.busy === 1'b1);
      monDonePrev = (jig.done === 1'b1);
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of runs.
  initial begin
    logic sawBusy;
    rst = 1'b1;
    faultMode = 0;
    testsRun = 0;
    testsFailed = 0;
    jig.start = 1'b0;
    jig.high_z_req = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("resetChainOut", 32'(jig.chain_out), 0);
    checkOutput("resetOe", 32'(jig.chain_oe), 0);
    checkOutput("resetBusy", 32'(jig.busy), 0);
    checkOutput("resetDone", 32'(jig.done), 0);
    checkOutput("resetPass", 32'(jig.pass), 0);
    checkOutput("resetMask", 32'(jig.fail_mask), 0);
    checkOutput("resetLed", 32'(jig.led_g), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("oeAfterReset", 32'(jig.chain_oe), 1);

    // Run 1: ideal loopback, with start latency, pattern and blink spot checks.
    applyStimulus(0, 1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("startLatencyEarly", 32'(jig.busy), 0);
    @(negedge clk);
    checkOutput("startLatency", 32'(jig.busy), 1);
    @(negedge clk);
    checkOutput("patZeros", 32'(jig.chain_out), 32'h0);
    checkOutput("ledBlinkLow", 32'(jig.led_g), 0);
    repeat (5) @(negedge clk);
    checkOutput("patOnes", 32'(jig.chain_out), 32'hf);
    checkOutput("ledBlinkHigh", 32'(jig.led_g), 1);
    repeat (5) @(negedge clk);
    checkOutput("patWalkOne0", 32'(jig.chain_out), 32'h1);
    repeat (20) @(negedge clk);
    checkOutput("patWalkZero0", 32'(jig.chain_out), 32'he);
    waitBusy("run1End", 1'b0, 40);
    repeat (2) @(negedge clk);

    // Run 2 (stuck ch2) then run 3 (ideal) back to back.
    applyStimulus(1, 1'b1, 4'b0100, 1'b0);
    waitBusy("run2Start", 1'b1, 10);
    waitBusy("run2End", 1'b0, 60);
    applyStimulus(0, 1'b1, 4'b0000, 1'b1);
    waitBusy("run3Start", 1'b1, 10);
    checkOutput("run3MaskCleared", 32'(jig.fail_mask), 0);
    checkOutput("run3DoneCleared", 32'(jig.done), 0);
    waitBusy("run3End", 1'b0, 60);
    repeat (2) @(negedge clk);

    // Run 4: ch1/ch2 short.
    applyStimulus(2, 1'b1, 4'b0110, 1'b0);
    waitBusy("run4Start", 1'b1, 10);
    waitBusy("run4End", 1'b0, 60);
    repeat (2) @(negedge clk);

    // Run 5: a second start pulse mid-run must not stretch the run.
    applyStimulus(0, 1'b1, 4'b0000, 1'b1);
    waitBusy("run5Start", 1'b1, 10);
    repeat (8) @(negedge clk);
    pulseStart();
    waitBusy("run5End", 1'b0, 60);
    repeat (2) @(negedge clk);

    // Run 6: reset mid-run clears everything on the next edge.
    applyStimulus(1, 1'b0, 4'b0000, 1'b0);
    waitBusy("run6Start", 1'b1, 10);
    repeat (28) @(negedge clk);
    checkOutput("partialMaskBeforeReset", 32'(jig.fail_mask), 32'h4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstChainOut", 32'(jig.chain_out), 0);
    checkOutput("midRstOe", 32'(jig.chain_oe), 0);
    checkOutput("midRstBusy", 32'(jig.busy), 0);
    checkOutput("midRstDone", 32'(jig.done), 0);
    checkOutput("midRstPass", 32'(jig.pass), 0);
    checkOutput("midRstMask", 32'(jig.fail_mask), 0);
    checkOutput("midRstLed", 32'(jig.led_g), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Run 7: high-Z request aborts the run and blocks new starts.
    applyStimulus(1, 1'b0, 4'b0000, 1'b0);
    waitBusy("run7Start", 1'b1, 10);
    repeat (20) @(negedge clk);
    jig.high_z_req = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("oeBeforeHighZ", 32'(jig.chain_oe), 1);
    checkOutput("busyBeforeAbort", 32'(jig.busy), 1);
    @(negedge clk);
    checkOutput("oeHighZ", 32'(jig.chain_oe), 0);
    checkOutput("abortBusy", 32'(jig.busy), 0);
    checkOutput("abortDone", 32'(jig.done), 0);
    checkOutput("abortPass", 32'(jig.pass), 0);
    checkOutput("abortMaskHeld", 32'(jig.fail_mask), 32'h4);
    checkOutput("abortChainOut", 32'(jig.chain_out), 0);
    sawBusy = 1'b0;
    pulseStart();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (jig.busy !== 1'b0) sawBusy = 1'b1;
    end
    checkOutput("startIgnoredHighZ", 32'(sawBusy), 0);
    jig.high_z_req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("oeReleaseEarly", 32'(jig.chain_oe), 0);
    @(negedge clk);
    checkOutput("oeRelease", 32'(jig.chain_oe), 1);

    // Run 8: ideal run after the abort.
    applyStimulus(0, 1'b1, 4'b0000, 1'b1);
    waitBusy("run8Start", 1'b1, 10);
    waitBusy("run8End", 1'b0, 60);
    repeat (3) @(negedge clk);

    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
